// File: rtl/hermitian_frame_mapper.sv
// Maps a frame of data carriers onto an NFFT-point Hermitian-symmetric spectrum.
// Ping-pong buffered: one bank fills while the other streams out.
module hermitian_frame_mapper #(
    parameter int DW    = 8,
    parameter int NFFT  = 64,
    parameter int NDATA = 31,
    localparam int KW   = $clog2(NFFT)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [KW-1:0] out_index,
    output logic          out_last,
    output logic          frame_err
);

    localparam int CW = $clog2(NDATA + 1);
    localparam int AW = (NDATA > 1) ? $clog2(NDATA) : 1;
    localparam logic [KW-1:0] KMAX = KW'(NFFT - 1);
    localparam logic [CW-1:0] CLOSE_AT = CW'(NDATA - 1);
    localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_q, state_d;
    logic [1:0]    full_q, full_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] len_q [2];
    logic          rdy_q;
    logic          err_q, err_d;
    logic          vld_q, vld_d;
    logic [DW-1:0] re_q, re_d;
    logic [DW-1:0] im_q, im_d;
    logic [KW-1:0] k_q, k_d;
    logic          last_q, last_d;

    logic [DW-1:0] mem_re_q [2][NDATA];
    logic [DW-1:0] mem_im_q [2][NDATA];

    logic          accept, at_end, close, rel;
    logic          load, ld_bank;
    logic [KW-1:0] ld_k;
    logic [KW-1:0] idx;
    logic          lo, hi, conj, hit;
    logic [DW-1:0] rd_re, rd_im, m_re, m_im;

    function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] v);
        if (v == MINV) return MAXV;
        return ~v + 1'b1;
    endfunction

    assign accept = in_valid && rdy_q;
    assign at_end = (wcnt_q == CLOSE_AT);
    assign close  = accept && (in_last || at_end);

    always_comb begin
        full_d  = full_q;
        wbank_d = wbank_q;
        wcnt_d  = wcnt_q;
        err_d   = 1'b0;
        if (accept) begin
            if (close) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wcnt_d          = '0;
                // early last, or a full bank without last
                err_d           = in_last ^ at_end;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
        if (rel) full_d[rbank_q] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        rbank_d = rbank_q;
        rel     = 1'b0;
        load    = 1'b0;
        ld_bank = rbank_q;
        ld_k    = k_q;
        unique case (state_q)
            IDLE: begin
                if (full_q[rbank_q]) begin
                    load    = 1'b1;
                    ld_k    = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (vld_q && out_ready) begin
                    if (k_q == KMAX) begin
                        rel     = 1'b1;
                        rbank_d = ~rbank_q;
                        if (full_q[~rbank_q]) begin
                            load    = 1'b1;
                            ld_bank = ~rbank_q;
                            ld_k    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        load = 1'b1;
                        ld_k = k_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx  = '0;
        conj = 1'b0;
        lo   = (ld_k != '0) && (int'(ld_k) <= NDATA);
        hi   = int'(ld_k) >= NFFT - NDATA;
        unique case (1'b1)
            lo: idx = ld_k - 1'b1;
            hi: begin
                idx  = KMAX - ld_k;
                conj = 1'b1;
            end
            default: ;
        endcase
        // carriers past a short frame's length read as zero
        hit   = (lo || hi) && (int'(idx) < int'(len_q[ld_bank]));
        rd_re = mem_re_q[ld_bank][idx[AW-1:0]];
        rd_im = mem_im_q[ld_bank][idx[AW-1:0]];
        m_re  = hit ? rd_re : '0;
        m_im  = !hit ? '0 : (conj ? neg_sat(rd_im) : rd_im);
    end

    always_comb begin
        vld_d  = (state_d == STREAM);
        re_d   = re_q;
        im_d   = im_q;
        k_d    = k_q;
        last_d = last_q;
        if (load) begin
            re_d   = m_re;
            im_d   = m_im;
            k_d    = ld_k;
            last_d = (ld_k == KMAX);
        end else if (state_d == IDLE) begin
            re_d   = '0;
            im_d   = '0;
            k_d    = '0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_re_q[wbank_q][wcnt_q[AW-1:0]] <= in_re;
            mem_im_q[wbank_q][wcnt_q[AW-1:0]] <= in_im;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q[0] <= '0;
            len_q[1] <= '0;
        end else if (close) begin
            len_q[wbank_q] <= wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            full_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wcnt_q  <= '0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            wcnt_q  <= wcnt_d;
            rdy_q   <= ~&full_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            re_q    <= re_d;
            im_q    <= im_d;
            k_q     <= k_d;
            last_q  <= last_d;
        end
    end

    assign in_ready  = rdy_q;
    assign frame_err = err_q;
    assign out_valid = vld_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_index = k_q;
    assign out_last  = last_q;

endmodule
